// File: rtl/store_unit.sv
// store_unit: RV32 store path that splits misaligned SB/SH/SW stores into one or two
// word-aligned memory beats with byte enables, signalling completion or illegal width.
module store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [2:0]        st_type,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              st_done,
   output logic              st_err
);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;
   state_t            state_q, state_d;
   logic              ready_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       sdata_q, sdata_d;
   logic [7:0]        smask_q, smask_d;
   logic              done_q, done_d, err_q, err_d;
   logic              accept, legal;
   logic [31:0]       dmask;
   logic [3:0]        base;

   assign accept = st_valid & st_ready;
   assign legal  = (st_type == 3'b000) | (st_type == 3'b001) | (st_type == 3'b010);
   assign dmask  = st_type == 3'b000 ? {24'b0, st_data[7:0]} :
                   st_type == 3'b001 ? {16'b0, st_data[15:0]} : st_data;
   assign base   = st_type == 3'b000 ? 4'b0001 : st_type == 3'b001 ? 4'b0011 : 4'b1111;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept && legal ? BEAT1 : IDLE;
         BEAT1:   state_d = !mem_gnt ? BEAT1 : |smask_q[7:4] ? BEAT2 : IDLE;
         BEAT2:   state_d = mem_gnt ? IDLE : BEAT2;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      st_ready  = (state_q == IDLE) & ready_q;
      mem_req   = state_q != IDLE;
      mem_addr  = state_q == BEAT1 ? addr_q : state_q == BEAT2 ? addr_q + ADDR_W'(4) : '0;
      mem_wdata = state_q == BEAT1 ? sdata_q[31:0] : state_q == BEAT2 ? sdata_q[63:32] : '0;
      mem_be    = state_q == BEAT1 ? smask_q[3:0] : state_q == BEAT2 ? smask_q[7:4] : '0;
      st_done   = done_q;
      st_err    = err_q;
   end

   // capture only on a legal accept so the beat registers stay put during stalls
   always_comb begin
      addr_d  = addr_q;
      sdata_d = sdata_q;
      smask_d = smask_q;
      if (accept && legal) begin
         addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
         sdata_d = {32'b0, dmask} << {st_addr[1:0], 3'b000};
         smask_d = {4'b0, base} << st_addr[1:0];
      end
      done_d = (state_q == BEAT1 && mem_gnt && smask_q[7:4] == 4'b0) || (state_q == BEAT2 && mem_gnt);
      err_d  = accept && !legal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         addr_q  <= '0;
         sdata_q <= '0;
         smask_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         smask_q <= smask_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and random stores checked against a byte-level model of
// where each store byte lands in memory.
module tb_store_unit;
   logic        clk = 1'b0, rst_n = 1'b0, st_valid = 1'b0, mem_gnt = 1'b0;
   logic [31:0] st_addr = '0, st_data = '0;
   logic [2:0]  st_type = '0;
   logic        st_ready, mem_req, st_done, st_err;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   int          checks = 0, errors = 0;
   logic [31:0] ea[2], ed[2];
   logic [3:0]  eb[2];
   int          nb;

   store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .st_done(st_done), .st_err(st_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // each store byte k goes to byte address a+k; the beat is chosen by its word
   task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      int size, b, lane;
      logic [31:0] x;
      size = t == 3'd0 ? 1 : t == 3'd1 ? 2 : 4;
      ea[0] = {a[31:2], 2'b00};
      ea[1] = ea[0] + 32'd4;
      ed[0] = '0; ed[1] = '0; eb[0] = '0; eb[1] = '0;
      for (int k = 0; k < size; k++) begin
         x = a + k;
         b = (x[31:2] != a[31:2]) ? 1 : 0;
         lane = int'(x[1:0]);
         ed[b][lane*8 +: 8] = d[k*8 +: 8];
         eb[b][lane] = 1'b1;
      end
      nb = eb[1] != 4'b0 ? 2 : 1;
   endtask

   // entered and left at a negedge; stall < 0 picks a random stall per beat
   task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t, input int stall);
      int s;
      model(a, d, t);
      chk("ready_before", st_ready, 1);
      st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
      @(posedge clk); @(negedge clk);
      st_valid = 1'b0; st_addr = $urandom; st_data = $urandom;
      for (int i = 0; i < nb; i++) begin
         s = stall < 0 ? int'($urandom_range(0, 3)) : stall;
         for (int j = 0; j <= s; j++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, ea[i]);
            chk("mem_wdata", mem_wdata, ed[i]);
            chk("mem_be", mem_be, eb[i]);
            chk("ready_busy", st_ready, 0);
            chk("done_early", st_done, 0);
            mem_gnt = (j == s);
            @(posedge clk); @(negedge clk);
         end
         mem_gnt = 1'b0;
      end
      chk("st_done", st_done, 1);
      chk("req_after", mem_req, 0);
      chk("be_after", mem_be, 0);
      chk("addr_after", mem_addr, 0);
      chk("ready_after", st_ready, 1);
   endtask

   task automatic idle_check();
      @(negedge clk);
      chk("idle_done", st_done, 0);
      chk("idle_err", st_err, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_wdata", mem_wdata, 0);
      chk("idle_ready", st_ready, 1);
   endtask

   task automatic illegal(input logic [2:0] t);
      chk("ready_before_ill", st_ready, 1);
      st_valid = 1'b1; st_addr = 32'h0; st_type = t; mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      st_valid = 1'b0;
      chk("st_err", st_err, 1);
      chk("ill_req", mem_req, 0);
      chk("ill_ready", st_ready, 1);
      chk("ill_done", st_done, 0);
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("err_pulse", st_err, 0);
      chk("ill_req2", mem_req, 0);
   endtask

   initial begin
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_ready", st_ready, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_done", st_done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_post_rst", st_ready, 1);
      run_store(32'h102, 32'h12345678, 3'd0, 0);
      idle_check();
      run_store(32'h003, 32'h12345678, 3'd1, 0);
      idle_check();
      run_store(32'h009, 32'h12345678, 3'd2, 0);
      idle_check();
      run_store(32'h008, 32'h00FF0000, 3'd2, 3);
      idle_check();
      illegal(3'd3);
      run_store(32'hFFFFFFFE, 32'hCAFEBABE, 3'd2, 1);
      run_store(32'h0000_0007, 32'hA5A5_1234, 3'd1, 0);
      idle_check();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) == 0) illegal(3'(3 + $urandom_range(0, 4)));
         else run_store($urandom, $urandom, 3'($urandom_range(0, 2)), -1);
         if ($urandom_range(0, 1) == 0) idle_check();
      end
      st_valid = 1'b1; st_addr = 32'h009; st_data = 32'h12345678; st_type = 3'd2;
      @(posedge clk); @(negedge clk);
      st_valid = 1'b0;
      chk("rb_beat1", mem_addr, 32'h008);
      mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_gnt = 1'b0;
      chk("rb_beat2_req", mem_req, 1);
      chk("rb_beat2_addr", mem_addr, 32'h00C);
      #2 rst_n = 1'b0;
      #1;
      chk("rb_req", mem_req, 0);
      chk("rb_addr", mem_addr, 0);
      chk("rb_wdata", mem_wdata, 0);
      chk("rb_be", mem_be, 0);
      chk("rb_ready", st_ready, 0);
      chk("rb_done", st_done, 0);
      @(negedge clk);
      chk("rb_done2", st_done, 0);
      chk("rb_req2", mem_req, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rb_ready_rel", st_ready, 1);
      chk("rb_done_rel", st_done, 0);
      run_store(32'h040, 32'h89ABCDEF, 3'd2, 0);
      idle_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the request and memory ports.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid  input  1  store request present.
REQ-005 SHALL have port st_ready  output  1  unit can accept a request.
REQ-006 SHALL have port st_addr  input  ADDR_W  byte address of the store.
REQ-007 SHALL have port st_data  input  32  register data (rs2), right-justified.
REQ-008 SHALL have port st_type  input  3  store width code: 000 SB, 001 SH, 010 SW; all other codes illegal.
REQ-009 SHALL have port mem_req  output  1  memory write request.
REQ-010 SHALL have port mem_gnt  input  1  memory accepts the current beat.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word-aligned beat address (bits [1:0] = 00).
REQ-012 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-014 SHALL have port st_done  output  1  one-cycle pulse: store fully written.
REQ-015 SHALL have port st_err  output  1  one-cycle pulse: illegal st_type, no bus access.

Function
REQ-016 SHALL implement states IDLE, BEAT1, BEAT2; st_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when st_valid and st_ready are both 1, capturing addr, data and type in that cycle.
REQ-018 SHALL form a 64-bit shifted word sdata = {32'b0, st_data} << (8*addr[1:0]) and 8-bit mask smask = base << addr[1:0], base 0001 (SB), 0011 (SH), 1111 (SW).
REQ-019 SHALL mask unused st_data bytes to zero before shifting (SB keeps [7:0], SH keeps [15:0]).
REQ-020 SHALL, on a legal accept, enter BEAT1 next cycle, driving mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata=sdata[31:0], mem_be=smask[3:0].
REQ-021 SHALL, on a beat with mem_req and mem_gnt both 1 in BEAT1, go to BEAT2 if smask[7:4] is non-zero, else go to IDLE and pulse st_done for exactly one cycle in the next cycle.
REQ-022 SHALL in BEAT2 drive mem_req=1, mem_addr=BEAT1 address + 4 (wrapping modulo 2^ADDR_W), mem_wdata=sdata[63:32], mem_be=smask[7:4]; on grant go to IDLE and pulse st_done next cycle.
REQ-023 SHALL hold mem_addr, mem_wdata and mem_be stable while mem_req=1 and mem_gnt=0 (unbounded stall).
REQ-024 SHALL drive mem_req=0, mem_be=0000, mem_wdata=0 and mem_addr=0 in IDLE.
REQ-025 SHALL, on an accept with illegal st_type, stay in IDLE, never assert mem_req, and pulse st_err for one cycle in the next cycle.
REQ-026 SHALL ignore mem_gnt when mem_req=0.
REQ-027 SHALL give minimum latency accept -> st_done of 2 cycles (single beat, immediate grant), and 3 cycles for split stores.
REQ-028 SHALL allow a new accept in the same cycle that st_done or st_err is high (back-to-back stores).

Reset
REQ-029 SHALL, while rst_n=0, immediately force state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0000, st_done=0, st_err=0, st_ready=0.
REQ-030 SHALL hold st_ready=1 from the first clock edge after rst_n deasserts.
REQ-031 SHALL abandon any in-progress store when reset asserts mid-beat (BEAT1 or BEAT2), with no further bus beat and no st_done.

Verification
REQ-032 SHALL check SB addr 0x102 data 0x12345678 -> one beat: mem_addr 0x100, mem_wdata 0x00780000, mem_be 0100; st_done 2 cycles after accept.
REQ-033 SHALL check SH addr 0x003 data 0x12345678 -> beat1 addr 0x000, wdata 0x78000000, be 1000; beat2 addr 0x004, wdata 0x00000056, be 0001.
REQ-034 SHALL check SW addr 0x009 data 0x12345678 -> beat1 addr 0x008, wdata 0x34567800, be 1110; beat2 addr 0x00C, wdata 0x00000012, be 0001.
REQ-035 SHALL check SW addr 0x008 data 0x00FF0000 with mem_gnt low 3 cycles -> outputs stable 0x008/0x00FF0000/1111 throughout stall; st_done the cycle after grant.
REQ-036 SHALL check st_type 011 addr 0x000 -> st_err one cycle, mem_req never asserted, st_ready stays 1.
REQ-037 SHALL check rst_n pulled low during BEAT2 of a split SW -> outputs zero immediately, no st_done, clean accept of the next request after release.
